// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//
// Purpose:
//   Shares a single WIDTH-bit ripple-carry adder between two requesters, A
//   and B. The adder is built from full_adder cells. Arbitration is
//   round-robin. The sum and carry-out are held in a single registered
//   result slot. The result slot is handed downstream with a valid/ready
//   handshake. When the consumer never stalls, the block completes one add
//   per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   a_valid    requester A has an operation pending
//   a_x, a_y   A operands (WIDTH bits)
//   a_cin      A carry-in
//   a_ready    A request is accepted this cycle
//   b_valid    requester B has an operation pending
//   b_x, b_y   B operands (WIDTH bits)
//   b_cin      B carry-in
//   b_ready    B request is accepted this cycle
//   rsp_valid  result register holds an unconsumed result
//   rsp_ready  consumer takes the result
//   rsp_sum    registered sum (WIDTH bits)
//   rsp_carry  registered carry-out
//   rsp_id     owner of the result: 0 = A, 1 = B
//
// Optional feature (macro ADDER_ARB_STATS_EN):
//   a_grants   8-bit saturating count of accepts from A
//   b_grants   8-bit saturating count of accepts from B
// ---------------------------------------------------------------------------

// One-bit full adder cell; the shared adder is a ripple chain of these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module adder_share_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_x,
    input  logic [WIDTH-1:0] a_y,
    input  logic             a_cin,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_x,
    input  logic [WIDTH-1:0] b_y,
    input  logic             b_cin,
    output logic             b_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             rsp_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [7:0]       a_grants,
    output logic [7:0]       b_grants
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slotState_t;

    slotState_t       state_q, state_d;
    logic [WIDTH-1:0] rspSum_q, rspSum_d;
    logic             rspCarry_q, rspCarry_d;
    logic             rspId_q, rspId_d;
    // Owner of the most recent accept: 0 = A, 1 = B.
    logic             lastGrant_q, lastGrant_d;

    logic             slotFree;
    logic             grantA;
    logic             grantB;
    logic             acceptA;
    logic             acceptB;
    logic [WIDTH-1:0] opX;
    logic [WIDTH-1:0] opY;
    logic             opCin;
    logic [WIDTH-1:0] addSum;
    logic [WIDTH:0]   carryChain;

    // The slot can take a new result when it is empty, or when the current
    // result is being consumed at the same edge.
    assign slotFree = (state_q == EMPTY) || rsp_ready;

    // Round-robin grant. When both requesters are valid, the one that did
    // not win last time is chosen. Each grant is qualified by its own valid,
    // so a ready is never raised toward an idle requester.
    always_comb begin
        grantA = a_valid && (!b_valid || lastGrant_q);
        grantB = b_valid && (!a_valid || !lastGrant_q);
    end

    assign a_ready = slotFree && grantA;
    assign b_ready = slotFree && grantB;
    assign acceptA = a_valid && a_ready;
    assign acceptB = b_valid && b_ready;

    // Operand mux in front of the shared adder. A is the default path; the
    // adder output is only captured on an accept, so it does not matter
    // what the adder computes in idle cycles.
    assign opX   = grantB ? b_x   : a_x;
    assign opY   = grantB ? b_y   : a_y;
    assign opCin = grantB ? b_cin : a_cin;

    // Ripple-carry chain. The carry-in is fed from the requester, so the
    // result is the full (WIDTH+1)-bit value x + y + cin.
    assign carryChain[0] = opCin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (opX[i]),
            .b    (opY[i]),
            .cin  (carryChain[i]),
            .sum  (addSum[i]),
            .cout (carryChain[i+1])
        );
    end

    // Next-state and result-slot update.
    // An accept always fills the slot; this also covers the back-to-back
    // case where a consume and an accept happen at the same edge.
    // A consume without an accept empties the slot. In every other case
    // the slot keeps its contents, so the result stays stable while the
    // consumer stalls.
    always_comb begin
        state_d     = state_q;
        rspSum_d    = rspSum_q;
        rspCarry_d  = rspCarry_q;
        rspId_d     = rspId_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            EMPTY: begin
                if (acceptA || acceptB) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!(acceptA || acceptB) && rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (acceptA || acceptB) begin
            rspSum_d    = addSum;
            rspCarry_d  = carryChain[WIDTH];
            rspId_d     = acceptB;
            lastGrant_d = acceptB;
        end
    end

    // Reset sets last_grant to B, so A wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            rspSum_q    <= '0;
            rspCarry_q  <= 1'b0;
            rspId_q     <= 1'b0;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            rspSum_q    <= rspSum_d;
            rspCarry_q  <= rspCarry_d;
            rspId_q     <= rspId_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = rspSum_q;
    assign rsp_carry = rspCarry_q;
    assign rsp_id    = rspId_q;

`ifdef ADDER_ARB_STATS_EN
    logic [7:0] aGrants_q;
    logic [7:0] bGrants_q;

    // Saturating accept counters. Each counter holds at 255 once it
    // reaches that value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aGrants_q <= 8'd0;
            bGrants_q <= 8'd0;
        end else begin
            if (acceptA && (aGrants_q != 8'hFF)) begin
                aGrants_q <= aGrants_q + 8'd1;
            end
            if (acceptB && (bGrants_q != 8'hFF)) begin
                bGrants_q <= bGrants_q + 8'd1;
            end
        end
    end

    assign a_grants = aGrants_q;
    assign b_grants = bGrants_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arbiter
//
// Purpose:
//   Directed testbench for adder_share_arbiter. It drives hand-computed
//   vectors into the design and checks the results with immediate
//   assertions. The stats counters are also exercised when
//   ADDER_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_adder_share_arbiter;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst_n;
    logic             aValid;
    logic [WIDTH-1:0] aX;
    logic [WIDTH-1:0] aY;
    logic             aCin;
    logic             aReady;
    logic             bValid;
    logic [WIDTH-1:0] bX;
    logic [WIDTH-1:0] bY;
    logic             bCin;
    logic             bReady;
    logic             rspValid;
    logic             rspReady;
    logic [WIDTH-1:0] rspSum;
    logic             rspCarry;
    logic             rspId;
`ifdef ADDER_ARB_STATS_EN
    logic [7:0]       aGrants;
    logic [7:0]       bGrants;
`endif

    int checkCount = 0;
    int errorCount = 0;

    adder_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (aValid),
        .a_x       (aX),
        .a_y       (aY),
        .a_cin     (aCin),
        .a_ready   (aReady),
        .b_valid   (bValid),
        .b_x       (bX),
        .b_y       (bY),
        .b_cin     (bCin),
        .b_ready   (bReady),
        .rsp_valid (rspValid),
        .rsp_ready (rspReady),
        .rsp_sum   (rspSum),
        .rsp_carry (rspCarry),
        .rsp_id    (rspId)
`ifdef ADDER_ARB_STATS_EN
        ,
        .a_grants  (aGrants),
        .b_grants  (bGrants)
`endif
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a new input vector just after a falling edge, then give the
    // combinational ready path time to settle.
    task automatic applyStimulus(input logic av, input logic [WIDTH-1:0] ax,
                                 input logic [WIDTH-1:0] ay, input logic acin,
                                 input logic bv, input logic [WIDTH-1:0] bx,
                                 input logic [WIDTH-1:0] by, input logic bcin,
                                 input logic rr);
        @(negedge clk);
        aValid   = av;
        aX       = ax;
        aY       = ay;
        aCin     = acin;
        bValid   = bv;
        bX       = bx;
        bY       = by;
        bCin     = bcin;
        rspReady = rr;
        #1;
    endtask

    // Advance through one rising edge and sample 1 ns later.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value with the expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("[TB] check %s mismatched", tag);
        end
    endtask

    // Check all four response fields together.
    task automatic checkRsp(input string tag, input logic v, input logic [WIDTH-1:0] s,
                            input logic c, input logic id);
        checkOutput({tag, ".valid"}, 32'(rspValid), 32'(v));
        checkOutput({tag, ".sum"},   32'(rspSum),   32'(s));
        checkOutput({tag, ".carry"}, 32'(rspCarry), 32'(c));
        checkOutput({tag, ".id"},    32'(rspId),    32'(id));
    endtask

    initial begin
        rst_n    = 1'b0;
        aValid   = 1'b0;
        aX       = '0;
        aY       = '0;
        aCin     = 1'b0;
        bValid   = 1'b0;
        bX       = '0;
        bY       = '0;
        bCin     = 1'b0;
        rspReady = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkRsp("reset", 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("reset.aReady", 32'(aReady), 32'd0);
        checkOutput("reset.bReady", 32'(bReady), 32'd0);
`ifdef ADDER_ARB_STATS_EN
        checkOutput("reset.aGrants", 32'(aGrants), 32'd0);
        checkOutput("reset.bGrants", 32'(bGrants), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // A alone: 3 + 4 + 0 = 7
        applyStimulus(1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("aOnly.aReady", 32'(aReady), 32'd1);
        checkOutput("aOnly.bReady", 32'(bReady), 32'd0);
        stepClock();
        checkRsp("aOnly", 1'b1, 5'd7, 1'b0, 1'b0);

        // B alone: 31 + 31 + 1 = 63 -> sum 31, carry 1
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd31, 5'd31, 1'b1, 1'b1);
        checkOutput("bMax.bReady", 32'(bReady), 32'd1);
        checkOutput("bMax.aReady", 32'(aReady), 32'd0);
        stepClock();
        checkRsp("bMax", 1'b1, 5'd31, 1'b1, 1'b1);

        // B alone: 16 + 16 + 0 = 32 -> sum 0, carry 1
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd16, 5'd16, 1'b0, 1'b1);
        stepClock();
        checkRsp("bWrap", 1'b1, 5'd0, 1'b1, 1'b1);

        // Consume with no new request empties the slot
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        stepClock();
        checkOutput("drain.valid", 32'(rspValid), 32'd0);

        // Both valid for six cycles: A (1+2+0=3) and B (10+5+1=16) alternate
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd10, 5'd5, 1'b1, 1'b1);
            stepClock();
            if (i % 2 == 0) begin
                checkRsp($sformatf("rr%0d", i), 1'b1, 5'd3, 1'b0, 1'b0);
            end else begin
                checkRsp($sformatf("rr%0d", i), 1'b1, 5'd16, 1'b0, 1'b1);
            end
        end

        // Stall for 3 cycles while holding B's result (16)
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd10, 5'd5, 1'b1, 1'b0);
            checkOutput($sformatf("stall%0d.aReady", i), 32'(aReady), 32'd0);
            checkOutput($sformatf("stall%0d.bReady", i), 32'(bReady), 32'd0);
            stepClock();
            checkRsp($sformatf("stall%0d", i), 1'b1, 5'd16, 1'b0, 1'b1);
        end
        // Release the stall: consume and accept A at the same edge
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd10, 5'd5, 1'b1, 1'b1);
        checkOutput("unstall.aReady", 32'(aReady), 32'd1);
        checkOutput("unstall.bReady", 32'(bReady), 32'd0);
        stepClock();
        checkRsp("unstall", 1'b1, 5'd3, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle while a result is held
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("preRst.valid", 32'(rspValid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRst.valid", 32'(rspValid), 32'd0);
        checkOutput("asyncRst.sum", 32'(rspSum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // last_grant was A before reset; reset must restore the A-first tie-break
        applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 5'd8, 1'b0, 1'b1);
        checkOutput("postRst.aReady", 32'(aReady), 32'd1);
        checkOutput("postRst.bReady", 32'(bReady), 32'd0);
        stepClock();
        checkRsp("postRst", 1'b1, 5'd12, 1'b0, 1'b0);

`ifdef ADDER_ARB_STATS_EN
        // 300 A-only accepts saturate the A counter at 255
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("stats.aGrants", 32'(aGrants), 32'd255);
        checkOutput("stats.bGrants", 32'(bGrants), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit ripple adder, built from the existing full_adder cells, between two requesters, A and B.
- Uses a valid/ready handshake on each request port and on the single response port.
- Round-robin arbitration; the sum and carry are registered; sustains one add per cycle when the response side is not stalled.
- Sits between the two operand sources and the downstream result consumer in the lab datapath.

Parameters:
- WIDTH, 5, operand and sum width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  requester A has an operation
- a_x  input  WIDTH  A operand x
- a_y  input  WIDTH  A operand y
- a_cin  input  1  A carry-in
- a_ready  output  1  A request accepted this cycle (when a_valid=1)
- b_valid  input  1  requester B has an operation
- b_x  input  WIDTH  B operand x
- b_y  input  WIDTH  B operand y
- b_cin  input  1  B carry-in
- b_ready  output  1  B request accepted this cycle (when b_valid=1)
- rsp_valid  output  1  result register holds an unconsumed result
- rsp_ready  input  1  consumer takes the result
- rsp_sum  output  WIDTH  registered sum
- rsp_carry  output  1  registered carry-out
- rsp_id  output  1  0 = result belongs to A, 1 = result belongs to B

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, last_grant=B. With last_grant=B, A wins the first tie.
- Arithmetic: {carry, sum} = x + y + cin, computed as a full (WIDTH+1)-bit result.
  - cin is honoured; it is never tied to 0.
  - Example: 31 + 31 + 1 gives sum=31, carry=1.
- Result slot: one result register.
  - slot_free = !rsp_valid || rsp_ready.
- Grant, combinational from the current valids and last_grant:
  - only A valid: grant A;
  - only B valid: grant B;
  - both valid: grant whichever is not last_grant;
  - none valid: no grant.
- Ready outputs:
  - a_ready = slot_free && grant==A;
  - b_ready = slot_free && grant==B.
  - At most one ready is high per cycle.
  - A ready is never asserted to a requester whose valid is low.
- Accept: valid && ready at a clock edge. On accept:
  - the adder output is captured into rsp_sum and rsp_carry;
  - rsp_id is set to the requester;
  - rsp_valid is set to 1;
  - last_grant is set to the requester.
- Latency: request accepted at edge N gives rsp_valid=1 from edge N; the result is visible in the cycle after the accepting cycle.
- Response handshake:
  - rsp_valid stays high, and rsp_sum, rsp_carry and rsp_id stay stable, until rsp_valid && rsp_ready.
  - If consume and accept happen at the same edge, the new result replaces the old one and rsp_valid stays 1 (back-to-back, one per cycle).
  - If consume happens with no accept, rsp_valid goes to 0.
- Backpressure: with rsp_valid=1 and rsp_ready=0, both ready outputs are 0. No request is dropped or overwritten.
- Requester rule: a requester holds valid and its operands stable until it sees ready. The arbiter may switch grant between cycles while stalled, following the round-robin rule.
- Fairness: with both requesters continuously valid and no stall, grants alternate A, B, A, B...
- State machine: two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - EMPTY to FULL on accept.
  - FULL to FULL on accept, or on no consume.
  - FULL to EMPTY on consume without accept.
- Reset mid-operation: any held result is discarded. rsp_valid drops immediately (asynchronous) and last_grant returns to B.

Optional Feature:
- Macro ADDER_ARB_STATS_EN.
- When defined, adds two output ports:
  - a_grants  output  8  saturating count of accepts from A;
  - b_grants  output  8  saturating count of accepts from B.
- Both counters reset to 0, increment on each accept, and stick at 255.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, then A valid with x=3, y=4, cin=0, rsp_ready=1 -> a_ready=1 same cycle; next cycle rsp_valid=1, sum=7, carry=0, id=0.
- B valid with x=31, y=31, cin=1 -> rsp_sum=31, rsp_carry=1, id=1; also B with x=16, y=16, cin=0 -> sum=0, carry=1.
- A and B both valid continuously for 6 cycles with rsp_ready=1 -> ids 0,1,0,1,0,1 on consecutive cycles; rsp_valid never drops.
- Result held with rsp_ready=0 for 3 cycles while A and B are valid -> a_ready=b_ready=0; rsp fields stable; raise rsp_ready -> old result consumed, next grant accepted in the same edge.
- Assert rst_n=0 asynchronously, mid-cycle, while rsp_valid=1 -> rsp_valid=0 immediately; after release both valid -> A granted first.
- With ADDER_ARB_STATS_EN: 300 A-only accepts -> a_grants=255, b_grants=0.
